// File: rtl/lit_fifo_reader_if.sv
// Bundles the literal FIFO read port and the downstream literal write-command handshake.
// The master modport is the reader's view; the slave modport is the FIFO/consumer side.
interface lit_fifo_reader_if #(
   parameter int unsigned WIDTH = 85
);
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             lit_valid;
   logic             lit_ready;
   logic [15:0]      lit_addr;
   logic [63:0]      lit_data;
   logic [7:0]       lit_mask;
   logic             lit_last;

   modport master (
      input  fifo_empty, fifo_dout, lit_ready,
      output fifo_rd_en, lit_valid, lit_addr, lit_data, lit_mask, lit_last
   );

   modport slave (
      output fifo_empty, fifo_dout, lit_ready,
      input  fifo_rd_en, lit_valid, lit_addr, lit_data, lit_mask, lit_last
   );
endinterface

// File: rtl/lit_fifo_reader.sv
// Pops literal tokens from the parser FIFO (1-cycle registered read), buffers them in a
// 2-entry skid buffer and presents byte-masked write commands with valid/ready.
module lit_fifo_reader #(
   parameter int unsigned WIDTH      = 85,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   lit_fifo_reader_if.master     bus,
   output logic [31:0]           byte_count_o,
   output logic                  done_o,
   output logic                  len_err_o
);

   localparam int unsigned LastBit = WIDTH - 1;
   localparam logic [1:0]  Credits = 2'(SKID_DEPTH);

   typedef struct packed {
      logic        last;
      logic [7:0]  mask;
      logic [15:0] addr;
      logic [63:0] data;
   } entry_t;

   entry_t      head_q, head_d, tail_q, tail_d, tok;
   logic [1:0]  occ_q, occ_d;
   logic        inflight_q;
   logic [31:0] byte_count_q, byte_count_d;
   logic        done_q, done_d;
   logic        len_err_q, len_err_d;
   logic [3:0]  tok_len;
   logic [3:0]  pop_bytes;
   logic [1:0]  pending;
   logic        capture, hs, rd_en;

   // Token decode; mask bit i set for i < len, which clamps len > 8 to a full mask.
   always_comb begin
      tok_len   = bus.fifo_dout[LastBit-1 -: 4];
      tok.last  = bus.fifo_dout[LastBit];
      tok.addr  = bus.fifo_dout[79:64];
      tok.data  = bus.fifo_dout[63:0];
      tok.mask  = '0;
      for (int i = 0; i < 8; i++) begin
         tok.mask[i] = (4'(i) < tok_len);
      end
      capture   = inflight_q && ((tok_len != 4'd0) || tok.last);
   end

   always_comb begin
      hs      = (occ_q != 2'd0) && bus.lit_ready;
      pending = occ_q + 2'(inflight_q);
      // A slot freed by this cycle's handshake can be re-credited immediately.
      rd_en   = !rst && !bus.fifo_empty &&
                ((pending < Credits) || ((pending == Credits) && hs));
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (hs) begin
         head_d = tail_q;
         occ_d  = occ_q - 2'd1;
      end
      if (capture) begin
         if (occ_d == 2'd0) begin
            head_d = tok;
         end else begin
            tail_d = tok;
         end
         occ_d = occ_d + 2'd1;
      end

      pop_bytes = '0;
      for (int i = 0; i < 8; i++) begin
         pop_bytes = pop_bytes + 4'(head_q.mask[i]);
      end
      byte_count_d = byte_count_q + (hs ? 32'(pop_bytes) : 32'd0);
      done_d       = hs && head_q.last;
      len_err_d    = len_err_q || (inflight_q && (tok_len > 4'd8));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         occ_q        <= '0;
         inflight_q   <= 1'b0;
         byte_count_q <= '0;
         done_q       <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         occ_q        <= occ_d;
         inflight_q   <= rd_en;
         byte_count_q <= byte_count_d;
         done_q       <= done_d;
         len_err_q    <= len_err_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.lit_valid  = (occ_q != 2'd0);
   assign bus.lit_addr   = head_q.addr;
   assign bus.lit_data   = head_q.data;
   assign bus.lit_mask   = head_q.mask;
   assign bus.lit_last   = head_q.last;
   assign byte_count_o   = byte_count_q;
   assign done_o         = done_q;
   assign len_err_o      = len_err_q;

endmodule

// File: tb/tb_lit_fifo_reader.sv
// Directed bench for lit_fifo_reader: a queue-backed FIFO with 1-cycle read latency feeds
// the DUT; presented commands are collected and compared against hand-built expectations.
module tb_lit_fifo_reader;

   logic        clk;
   logic        rst;
   logic [31:0] byte_count_o;
   logic        done_o;
   logic        len_err_o;

   lit_fifo_reader_if #(.WIDTH(85)) bus ();

   lit_fifo_reader #(.WIDTH(85), .SKID_DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .byte_count_o (byte_count_o),
      .done_o       (done_o),
      .len_err_o    (len_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [84:0] fq[$];
   logic [88:0] exp_q[$];
   logic [88:0] got_q[$];
   bit          pend;
   int          mode;
   int          cyc;
   int          first_rd, last_rd, n_rd;
   int          first_vld, last_vld, n_vld;
   int          last_hs_cyc, n_done, done_cyc;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      exp_q.delete();
      got_q.delete();
      first_rd  = -1; last_rd  = -1; n_rd  = 0;
      first_vld = -1; last_vld = -1; n_vld = 0;
      last_hs_cyc = -1; n_done = 0; done_cyc = -1;
   endtask

   task automatic push(input bit last, input logic [3:0] len, input logic [15:0] addr,
                       input logic [63:0] data, input logic [7:0] exp_mask, input bit shown);
      fq.push_back({last, len, addr, data});
      if (shown) exp_q.push_back({last, exp_mask, addr, data});
   endtask

   // One clock: inputs change at negedge, outputs sampled 1 time unit later.
   task automatic run_cycle();
      @(negedge clk);
      if (pend) bus.fifo_dout = fq.pop_front();
      bus.fifo_empty = (fq.size() == 0);
      bus.lit_ready  = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'b0;
      #1;
      pend = bus.fifo_rd_en;
      if (bus.fifo_rd_en) begin
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
         n_rd++;
      end
      if (bus.lit_valid) begin
         if (first_vld < 0) first_vld = cyc;
         last_vld = cyc;
         n_vld++;
      end
      if (bus.lit_valid && bus.lit_ready) begin
         got_q.push_back({bus.lit_last, bus.lit_mask, bus.lit_addr, bus.lit_data});
         last_hs_cyc = cyc;
      end
      if (done_o) begin
         n_done++;
         done_cyc = cyc;
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      pend = 1'b0;
      fq.delete();
      bus.fifo_empty = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
   endtask

   task automatic compare_out(input string tag);
      check($sformatf("%s_count", tag), 96'(got_q.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_tok%0d", tag, i), 96'(got_q[i]), 96'(exp_q[i]));
      end
   endtask

   task automatic push_eight();
      for (int i = 0; i < 8; i++) begin
         push(1'b0, 4'd8, 16'(16'h0400 + i * 8), {8{8'(8'hA0 + i)}}, 8'hFF, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1;
      pend = 1'b0;
      mode = 0;
      cyc = 0;
      bus.fifo_empty = 1'b0;
      bus.fifo_dout  = '0;
      bus.lit_ready  = 1'b0;
      clear_stats();
      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_en",   96'(bus.fifo_rd_en), 96'd0);
      check("rst_valid",   96'(bus.lit_valid),  96'd0);
      check("rst_cmd",     96'({bus.lit_last, bus.lit_mask, bus.lit_addr, bus.lit_data}), 96'd0);
      check("rst_count",   96'(byte_count_o),   96'd0);
      check("rst_done",    96'(done_o),         96'd0);
      check("rst_len_err", 96'(len_err_o),      96'd0);
      bus.fifo_empty = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Single len=5 token.
      clear_stats();
      mode = 0;
      push(1'b0, 4'd5, 16'h0010, 64'h1122_3344_5566_7788, 8'h1F, 1'b1);
      run(8);
      check("t1_rd_cnt",  96'(n_rd), 96'd1);
      check("t1_latency", 96'(first_vld - first_rd), 96'd2);
      compare_out("t1");
      check("t1_bytes",   96'(byte_count_o), 96'd5);
      check("t1_len_err", 96'(len_err_o), 96'd0);
      check("t1_done",    96'(n_done), 96'd0);

      // Eight back-to-back full tokens, always ready.
      do_reset();
      mode = 0;
      push_eight();
      run(14);
      check("t2_rd_cnt",  96'(n_rd), 96'd8);
      check("t2_rd_span", 96'(last_rd - first_rd), 96'd7);
      check("t2_vld_cnt", 96'(n_vld), 96'd8);
      check("t2_vld_span", 96'(last_vld - first_vld), 96'd7);
      compare_out("t2");
      check("t2_bytes",   96'(byte_count_o), 96'd64);

      // Same tokens with ready toggling 1,0,0.
      do_reset();
      mode = 1;
      push_eight();
      run(40);
      compare_out("t3");
      check("t3_rd_cnt", 96'(n_rd), 96'd8);
      check("t3_bytes",  96'(byte_count_o), 96'd64);

      // Drop, short, over-long and empty-last tokens.
      do_reset();
      mode = 0;
      push(1'b0, 4'd0,  16'h0100, 64'hDEAD_BEEF_0000_0001, 8'h00, 1'b0);
      push(1'b0, 4'd3,  16'h0101, 64'h0000_0000_00CC_BBAA, 8'h07, 1'b1);
      push(1'b0, 4'd12, 16'h0104, 64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
      push(1'b1, 4'd0,  16'h010C, 64'h0000_0000_0000_0000, 8'h00, 1'b1);
      run(12);
      compare_out("t4");
      check("t4_bytes",    96'(byte_count_o), 96'd11);
      check("t4_len_err",  96'(len_err_o), 96'd1);
      check("t4_done_cnt", 96'(n_done), 96'd1);
      check("t4_done_cyc", 96'(done_cyc), 96'(last_hs_cyc + 1));

      // Asynchronous reset with one token buffered and one read in flight.
      do_reset();
      mode = 2;
      for (int i = 0; i < 4; i++) begin
         push(1'b0, 4'd8, 16'(16'h0800 + i), {8{8'(8'h51 + i)}}, 8'hFF, 1'b0);
      end
      run(3);
      check("t5_pre_valid", 96'(bus.lit_valid), 96'd1);
      #1 rst = 1'b1;
      #1;
      check("t5_async_valid", 96'(bus.lit_valid), 96'd0);
      check("t5_async_cmd",
            96'({bus.lit_last, bus.lit_mask, bus.lit_addr, bus.lit_data}), 96'd0);
      check("t5_async_rd",    96'(bus.fifo_rd_en), 96'd0);
      @(negedge clk);
      pend = 1'b0;
      fq.delete();
      bus.fifo_empty = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      mode = 0;
      run(4);
      check("t5_idle_rd",  96'(n_rd), 96'd0);
      check("t5_no_stale", 96'(n_vld), 96'd0);
      push(1'b0, 4'd2, 16'h0900, 64'h0000_0000_0000_5A5A, 8'h03, 1'b1);
      run(6);
      check("t5_rd_cnt", 96'(n_rd), 96'd1);
      compare_out("t5");
      check("t5_bytes", 96'(byte_count_o), 96'd2);

      // byte_count wrap: preset near 2^32, then add 6.
      do_reset();
      mode = 0;
      @(negedge clk);
      force dut.byte_count_q = 32'hFFFF_FFFC;
      @(negedge clk);
      release dut.byte_count_q;
      #1;
      check("t6_preset", 96'(byte_count_o), 96'hFFFF_FFFC);
      push(1'b0, 4'd6, 16'h0A00, 64'h0000_6655_4433_2211, 8'h3F, 1'b1);
      run(6);
      compare_out("t6");
      check("t6_wrap", 96'(byte_count_o), 96'h0000_0002);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
